// File: rtl/serial_subtractor_pkg.sv
// Purpose : shared constants and state type for the bit-serial subtractor.
// Latency : n/a (package only).
// Backpressure: n/a. Optional build macro used by this block: SERIAL_SUBTRACTOR_ADD_MODE_EN.
package serial_subtractor_pkg;

  // Default operand width.
  localparam int SS_WIDTH = 4;

  // State encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// Purpose : one-bit full subtractor (x - y - bi); with SERIAL_SUBTRACTOR_ADD_MODE_EN
//           it also acts as a full adder when op=0 (bi = carry-in, bo = carry-out).
// Latency : combinational. Backpressure: none.
// Ports   : x, y, bi (and op) in; diff, bo out.
module full_subtractor_cell (
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic op,
`endif
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  logic borrow;

  // Sum and difference bits are identical; only the carry/borrow chain differs.
  assign diff   = x ^ y ^ bi;
  assign borrow = (~x & y) | (~(x ^ y) & bi);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic carry;
  assign carry = (x & y) | ((x ^ y) & bi);
  assign bo    = op ? borrow : carry;
`else
  assign bo    = borrow;
`endif

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial d = a - b - bin, LSB first, one bit per clock, single borrow flop.
//           Optional macro SERIAL_SUBTRACTOR_ADD_MODE_EN adds input op (0=add, 1=subtract).
// Latency : start accepted at edge N -> done strobe in the cycle after edge N+WIDTH.
// Backpressure: none; start is ignored while busy (SHIFT), accepted in IDLE or DONE.
// Ports   : clk, rst (sync, active high), start, a, b, bin, [op] in;
//           busy, done, d, bout out. d/bout hold until the next done or reset.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] ra, rb;
  // Only WIDTH-1 result bits need storing: the last bit goes straight into d.
  logic [WIDTH-2:0] rr;
  logic [WIDTH-1:0] rr_shift;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             cell_diff, cell_bo;
  logic             load;
  logic             last;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic op_r;
`endif

  full_subtractor_cell u_cell (
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .op   (op_r),
`endif
    .x    (ra[0]),
    .y    (rb[0]),
    .bi   (br),
    .diff (cell_diff),
    .bo   (cell_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts the LSB holds the first bit.
  assign rr_shift = {cell_diff, rr};
  assign load     = start && (state == IDLE || state == DONE);
  assign last     = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_r  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        ra   <= a;
        rb   <= b;
        br   <= bin;
        cnt  <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        op_r <= op;
`endif
      end else if (state == SHIFT) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        rr  <= rr_shift[WIDTH-1:1];
        br  <= cell_bo;
        cnt <= cnt + 1'b1;
        if (last) begin
          d    <= rr_shift;
          bout <= cell_bo;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose : self-checking bench for serial_subtractor against an arithmetic reference model.
// Latency : checks done exactly WIDTH+1 cycles after start.
// Backpressure: exercises start-while-busy, back-to-back start and mid-operation reset.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = SS_WIDTH;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         op = 1'b1;
  logic         busy, done, bout;
  logic [W-1:0] d;

  int total = 0;
  int bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, modulo 2^W, with unsigned under/overflow flag.
  function automatic int ref_d(input int x, input int y, input int bi, input int o);
    int r;
    r = o ? (x - y - bi) : (x + y + bi);
    return r & MASK;
  endfunction

  function automatic int ref_b(input int x, input int y, input int bi, input int o);
    int r;
    r = o ? (x - y - bi) : (x + y + bi);
    return o ? int'(r < 0) : int'(r > MASK);
  endfunction

  // Drive a one-cycle start at a negedge; returns after the accepting posedge
  // at the next negedge (first SHIFT cycle).
  task automatic pulse_start(input int x, input int y, input int bi, input int o);
    @(negedge clk);
    start = 1'b1; a = W'(x); b = W'(y); bin = bi[0]; op = o[0];
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation with latency and result checks.
  task automatic run_op(input string tag, input int x, input int y, input int bi, input int o);
    pulse_start(x, y, bi, o);
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, ".busy"}, int'(busy), 1);
      check({tag, ".nodone"}, int'(done), 0);
    end
    @(negedge clk);
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".d"}, int'(d), ref_d(x, y, bi, o));
    check({tag, ".bout"}, int'(bout), ref_b(x, y, bi, o));
  endtask

  initial begin
    int x, y, bi, o;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.d", int'(d), 0);
    check("rst.bout", int'(bout), 0);

    // Directed subtract cases
    run_op("sub7_3", 7, 3, 0, 1);
    check("sub7_3.d_abs", int'(d), 4);
    run_op("sub3_7", 3, 7, 0, 1);
    check("sub3_7.d_abs", int'(d), 12);
    run_op("sub0_0_1", 0, 0, 1, 1);
    check("sub0_0_1.b_abs", int'(bout), 1);
    run_op("sub15_15", 15 & MASK, 15 & MASK, 0, 1);
    @(negedge clk);
    check("idle_after_done", int'(done), 0);

    // Start ignored while busy
    pulse_start(9, 2, 0, 1);
    @(negedge clk);
    start = 1'b1; a = W'(1); b = W'(1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W - 3; i++) @(negedge clk);
    check("ign.busy_last", int'(busy), 1);
    @(negedge clk);
    check("ign.done", int'(done), 1);
    check("ign.d", int'(d), 7);
    check("ign.bout", int'(bout), 0);

    // Back-to-back: start held through the DONE cycle
    start = 1'b1; a = W'(5); b = W'(6); bin = 1'b0; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      check("b2b.busy", int'(busy), 1);
      check("b2b.hold_d", int'(d), 7);
    end
    @(negedge clk);
    check("b2b.done", int'(done), 1);
    check("b2b.d", int'(d), ref_d(5, 6, 0, 1));
    check("b2b.bout", int'(bout), 1);
    // no second done from the ignored start
    begin
      int extra = 0;
      for (int i = 0; i < W + 2; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("b2b.no_extra_done", extra, 0);
    end

    // Reset in the 2nd SHIFT cycle
    pulse_start(12, 5, 1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst.busy", int'(busy), 0);
    check("mid_rst.done", int'(done), 0);
    check("mid_rst.d", int'(d), 0);
    check("mid_rst.bout", int'(bout), 0);
    begin
      int seen = 0;
      for (int i = 0; i < W + 2; i++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("mid_rst.quiet", seen, 0);
    end
    run_op("after_rst", 10, 3, 1, 1);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    run_op("add9_8", 9, 8, 0, 0);
    run_op("sub9_8", 9, 8, 0, 1);
`endif

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      x  = int'($urandom_range(0, MASK));
      y  = int'($urandom_range(0, MASK));
      bi = int'($urandom_range(0, 1));
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      o  = int'($urandom_range(0, 1));
`else
      o  = 1;
`endif
      run_op("rand", x, y, bi, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
